// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared op encodings and state types for the HI/LO
// multiply/divide unit and its iterative divider.
package mdu_hilo_pkg;

  // Op codes presented on op_i (zero-extended/truncated to OPW at use).
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  // Top-level sequencing: idle, multiply in flight, divide in flight.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } mdu_st_e;

  // Divider phases. The pre-step (magnitude and sign capture) is done on
  // the accepting edge, so the divider goes straight from idle to iterate.
  typedef enum logic [1:0] {
    DV_IDLE,
    DV_ITER,
    DV_FIX
  } div_st_e;

endpackage

// File: rtl/mdu_div.sv
// mdu_div: radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   go_i             start a division (operands sampled this edge)
//   sgn_i            1 = signed (DIV), 0 = unsigned (DIVU)
//   a_i, b_i         dividend, divisor
//   abort_i          drop the division in flight
//   q_o, r_o         sign-corrected quotient / remainder (valid with valid_o)
//   valid_o          high for the single fix-up cycle holding the result
// Timing: go at edge k -> iterate k+1..k+WIDTH -> valid_o in cycle k+WIDTH+1.
module mdu_div
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             valid_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_st_e          st_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, bmag_q;
  logic             a_neg_q, q_neg_q, dz_q;

  logic             a_neg, b_neg, take;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    a_neg  = sgn_i & a_i[WIDTH-1];
    b_neg  = sgn_i & b_i[WIDTH-1];
    a_mag  = a_neg ? -a_i : a_i;
    b_mag  = b_neg ? -b_i : b_i;
    // Shift the next dividend bit into the partial remainder and trial-subtract.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, bmag_q};
    take   = ~diff[WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= DV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (abort_i) begin
      st_q  <= DV_IDLE;
      cnt_q <= '0;
    end else begin
      case (st_q)
        DV_IDLE: if (go_i) begin
          st_q    <= DV_ITER;
          cnt_q   <= '0;
          quo_q   <= a_mag;
          rem_q   <= '0;
          bmag_q  <= b_mag;
          a_neg_q <= a_neg;
          q_neg_q <= a_neg ^ b_neg;
          dz_q    <= (b_i == '0);
        end
        DV_ITER: begin
          rem_q <= take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], take};
          if (cnt_q == CW'(WIDTH - 1)) begin
            st_q  <= DV_FIX;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DV_FIX:  st_q <= DV_IDLE;
        default: st_q <= DV_IDLE;
      endcase
    end
  end

  // Divide by zero: the raw iteration already leaves |A| in the remainder,
  // which the dividend-sign fix turns back into A; only the quotient is forced.
  // MIN / -1 falls out naturally: |MIN| = MIN, and negating MIN wraps to MIN.
  always_comb begin
    valid_o = (st_q == DV_FIX);
    q_o     = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    r_o     = a_neg_q ? -rem_q : rem_q;
  end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i, op_i  op strobe and code (accepted only when idle and no cancel)
//   rs_val_i       operand A / dividend / MTHI-MTLO data
//   rt_val_i       operand B / divisor
//   cancel_i       abort in-flight MULT/DIV; also blocks a same-cycle start
//   busy_o         MULT/DIV in flight
//   done_o         1-cycle pulse after HI/LO written by MULT/DIV
//   hi_o, lo_o     HI and LO registers
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int OPW      = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [OPW-1:0]   op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_st_e          st_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic acc, is_mul, is_div, mul_sgn, div_sgn, acc_mul, div_go, abort, mul_fin;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_d, mul_res;
  logic [WIDTH-1:0]   div_q, div_r;
  logic               div_valid;

  always_comb begin
    acc     = start_i & ~busy_q & ~cancel_i;
    mul_sgn = (op_i == OPW'(OP_MULT));
    div_sgn = (op_i == OPW'(OP_DIV));
    is_mul  = mul_sgn | (op_i == OPW'(OP_MULTU));
    is_div  = div_sgn | (op_i == OPW'(OP_DIVU));
    acc_mul = acc & is_mul;
    div_go  = acc & is_div;
    abort   = cancel_i & busy_q;
    // Sign/zero-extend to 2*WIDTH so one unsigned multiply serves both modes.
    a_ext   = mul_sgn ? {{WIDTH{rs_val_i[WIDTH-1]}}, rs_val_i} : {{WIDTH{1'b0}}, rs_val_i};
    b_ext   = mul_sgn ? {{WIDTH{rt_val_i[WIDTH-1]}}, rt_val_i} : {{WIDTH{1'b0}}, rt_val_i};
    prod_d  = a_ext * b_ext;
  end

  // Product register plus valid chain. HI/LO are written on the edge where the
  // token reaches the last stage, so done shows in cycle k+MULT_LAT.
  generate
    if (MULT_LAT == 1) begin : g_lat1
      assign mul_fin = acc_mul;
      assign mul_res = prod_d;
    end else begin : g_latn
      logic [MULT_LAT-2:0] vld_pipe_q;
      logic [2*WIDTH-1:0]  prod_q;
      always_ff @(posedge clk_i) begin
        if (rst_i || abort) vld_pipe_q <= '0;
        else                vld_pipe_q <= (vld_pipe_q << 1) | (MULT_LAT-1)'(acc_mul);
        if (rst_i)          prod_q <= '0;
        else if (acc_mul)   prod_q <= prod_d;
      end
      assign mul_fin = vld_pipe_q[MULT_LAT-2];
      assign mul_res = prod_q;
    end
  endgenerate

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .go_i    (div_go),
    .sgn_i   (div_sgn),
    .a_i     (rs_val_i),
    .b_i     (rt_val_i),
    .abort_i (abort),
    .q_o     (div_q),
    .r_o     (div_r),
    .valid_o (div_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        ST_IDLE: if (acc) begin
          if (op_i == OPW'(OP_MTHI)) hi_q <= rs_val_i;
          if (op_i == OPW'(OP_MTLO)) lo_q <= rs_val_i;
          if (is_mul) begin
            if (mul_fin) begin
              {hi_q, lo_q} <= mul_res;
              done_q       <= 1'b1;
            end else begin
              st_q   <= ST_MUL;
              busy_q <= 1'b1;
            end
          end
          if (is_div) begin
            st_q   <= ST_DIV;
            busy_q <= 1'b1;
          end
        end
        ST_MUL: if (cancel_i) begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end else if (mul_fin) begin
          {hi_q, lo_q} <= mul_res;
          done_q       <= 1'b1;
          st_q         <= ST_IDLE;
          busy_q       <= 1'b0;
        end
        ST_DIV: if (cancel_i) begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end else if (div_valid) begin
          hi_q   <= div_r;
          lo_q   <= div_q;
          done_q <= 1'b1;
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
